// File: rtl/bcd_time_pkg.sv
// Shared limits, segment patterns and BCD increment helper for the time-of-day counter.
// Segment patterns are active-high in {g,f,e,d,c,b,a} order.
package bcd_time_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } bcd_time_t;

    typedef struct packed {
        logic       carry;
        logic [7:0] value;
    } bcd_inc_t;

    // Increment a two-digit BCD field; wraps to 00 and flags a carry at the field limit.
    function automatic bcd_inc_t bcd_inc(input logic [7:0] val, input logic [7:0] max);
        bcd_inc_t r;
        r.carry = 1'b0;
        r.value = val;
        if (val == max) begin
            r.value = 8'h00;
            r.carry = 1'b1;
        end else if (val[3:0] == 4'd9) begin
            r.value = {val[7:4] + 4'd1, 4'h0};
        end else begin
            r.value = {val[7:4], val[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Registered BCD-nibble to seven-segment decoder; non-decimal nibbles blank the digit.
module bcd_to_seg7
    import bcd_time_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk50m,
    input  logic       rstn,
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    localparam logic [6:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    logic [6:0] seg_reg;
    logic [6:0] seg_next;
    logic [6:0] pattern;

    always_comb begin
        pattern = SEG_BLANK;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        seg_next = pattern ^ SEG_MASK;
    end

    always_ff @(posedge clk50m or negedge rstn) begin
        if (!rstn) begin
            seg_reg <= SEG_0 ^ SEG_MASK;
        end else begin
            seg_reg <= seg_next;
        end
    end

    assign seg = seg_reg;

endmodule

// File: rtl/bcd_time_keeper.sv
// 24-hour BCD time-of-day counter with adjust/clear, deferred tick on adjust collision,
// minute/day rollover pulses and six registered seven-segment digit drivers.
module bcd_time_keeper
    import bcd_time_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk50m,
    input  logic       rstn,
    input  logic       i_tick,
    input  logic       i_run,
    input  logic       i_clr,
    input  logic       i_inc_min,
    input  logic       i_inc_hour,
    output logic [7:0] o_sec_bcd,
    output logic [7:0] o_min_bcd,
    output logic [7:0] o_hour_bcd,
    output logic [6:0] o_hex0,
    output logic [6:0] o_hex1,
    output logic [6:0] o_hex2,
    output logic [6:0] o_hex3,
    output logic [6:0] o_hex4,
    output logic [6:0] o_hex5,
    output logic       o_min_pulse,
    output logic       o_day_pulse
);

    bcd_time_t time_reg;
    bcd_time_t time_next;
    logic      pending_reg;
    logic      pending_next;
    logic      min_pulse_reg;
    logic      min_pulse_next;
    logic      day_pulse_reg;
    logic      day_pulse_next;

    logic      qual_tick;
    logic      adjust;
    bcd_inc_t  sec_inc;
    bcd_inc_t  min_inc;
    bcd_inc_t  hour_inc;

    assign qual_tick = i_tick & i_run;
    assign adjust    = i_inc_min | i_inc_hour;
    assign sec_inc   = bcd_inc(time_reg.sec,  SEC_MAX);
    assign min_inc   = bcd_inc(time_reg.min,  MIN_MAX);
    assign hour_inc  = bcd_inc(time_reg.hour, HOUR_MAX);

    always_comb begin
        time_next      = time_reg;
        pending_next   = pending_reg;
        min_pulse_next = 1'b0;
        day_pulse_next = 1'b0;
        if (i_clr) begin
            time_next    = '0;
            pending_next = 1'b0;
        end else if (adjust) begin
            if (i_inc_min) begin
                time_next.min = min_inc.value;
            end
            if (i_inc_hour) begin
                time_next.hour = hour_inc.value;
            end
            // A tick colliding with an adjust is held and applied on the next free cycle.
            pending_next = pending_reg | qual_tick;
        end else if (qual_tick || pending_reg) begin
            pending_next  = 1'b0;
            time_next.sec = sec_inc.value;
            if (sec_inc.carry) begin
                time_next.min  = min_inc.value;
                min_pulse_next = 1'b1;
                if (min_inc.carry) begin
                    time_next.hour = hour_inc.value;
                    day_pulse_next = hour_inc.carry;
                end
            end
        end
    end

    always_ff @(posedge clk50m or negedge rstn) begin
        if (!rstn) begin
            time_reg      <= '0;
            pending_reg   <= 1'b0;
            min_pulse_reg <= 1'b0;
            day_pulse_reg <= 1'b0;
        end else begin
            time_reg      <= time_next;
            pending_reg   <= pending_next;
            min_pulse_reg <= min_pulse_next;
            day_pulse_reg <= day_pulse_next;
        end
    end

    assign o_sec_bcd   = time_reg.sec;
    assign o_min_bcd   = time_reg.min;
    assign o_hour_bcd  = time_reg.hour;
    assign o_min_pulse = min_pulse_reg;
    assign o_day_pulse = day_pulse_reg;

    // Nibble 0 is seconds units, nibble 5 is hours tens.
    logic [5:0][3:0] digit;
    logic [6:0]      hex_seg [6];

    assign digit = time_reg;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            bcd_to_seg7 #(
                .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
            ) u_seg (
                .clk50m(clk50m),
                .rstn  (rstn),
                .nibble(digit[gi]),
                .seg   (hex_seg[gi])
            );
        end
    endgenerate

    assign o_hex0 = hex_seg[0];
    assign o_hex1 = hex_seg[1];
    assign o_hex2 = hex_seg[2];
    assign o_hex3 = hex_seg[3];
    assign o_hex4 = hex_seg[4];
    assign o_hex5 = hex_seg[5];

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Bench for bcd_time_keeper: time held as seconds-of-day in a model, directed scenarios plus random traffic.
module tb_bcd_time_keeper;

    logic       clk50m = 1'b0;
    logic       rstn = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_run = 1'b0;
    logic       i_clr = 1'b0;
    logic       i_inc_min = 1'b0;
    logic       i_inc_hour = 1'b0;
    logic [7:0] o_sec_bcd;
    logic [7:0] o_min_bcd;
    logic [7:0] o_hour_bcd;
    logic [6:0] o_hex0;
    logic [6:0] o_hex1;
    logic [6:0] o_hex2;
    logic [6:0] o_hex3;
    logic [6:0] o_hex4;
    logic [6:0] o_hex5;
    logic       o_min_pulse;
    logic       o_day_pulse;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #10 clk50m = ~clk50m;

    bcd_time_keeper #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk50m     (clk50m),
        .rstn       (rstn),
        .i_tick     (i_tick),
        .i_run      (i_run),
        .i_clr      (i_clr),
        .i_inc_min  (i_inc_min),
        .i_inc_hour (i_inc_hour),
        .o_sec_bcd  (o_sec_bcd),
        .o_min_bcd  (o_min_bcd),
        .o_hour_bcd (o_hour_bcd),
        .o_hex0     (o_hex0),
        .o_hex1     (o_hex1),
        .o_hex2     (o_hex2),
        .o_hex3     (o_hex3),
        .o_hex4     (o_hex4),
        .o_hex5     (o_hex5),
        .o_min_pulse(o_min_pulse),
        .o_day_pulse(o_day_pulse)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // Expected DE2 (active-low) pattern for a digit value.
    function automatic logic [6:0] seg_lo(input logic [3:0] d);
        logic [6:0] hi;
        case (d)
            4'd0:    hi = 7'h3F;
            4'd1:    hi = 7'h06;
            4'd2:    hi = 7'h5B;
            4'd3:    hi = 7'h4F;
            4'd4:    hi = 7'h66;
            4'd5:    hi = 7'h6D;
            4'd6:    hi = 7'h7D;
            4'd7:    hi = 7'h07;
            4'd8:    hi = 7'h7F;
            4'd9:    hi = 7'h6F;
            default: hi = 7'h00;
        endcase
        return ~hi;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time as seconds since midnight, plus pending flag and pulses.
    int       m_t = 0;
    bit       m_pend = 1'b0;
    bit       m_mp = 1'b0;
    bit       m_dp = 1'b0;
    bit [7:0] p_s = 8'h00;
    bit [7:0] p_m = 8'h00;
    bit [7:0] p_h = 8'h00;
    int       mh;
    int       mm;
    int       ms;
    bit       mqt;

    always @(posedge clk50m or negedge rstn) begin
        if (!rstn) begin
            m_t = 0; m_pend = 1'b0; m_mp = 1'b0; m_dp = 1'b0;
            p_s = 8'h00; p_m = 8'h00; p_h = 8'h00;
        end else begin
            p_s = to_bcd(m_t % 60);
            p_m = to_bcd((m_t / 60) % 60);
            p_h = to_bcd(m_t / 3600);
            mqt = i_tick & i_run;
            m_mp = 1'b0;
            m_dp = 1'b0;
            if (i_clr) begin
                m_t = 0;
                m_pend = 1'b0;
            end else if (i_inc_min || i_inc_hour) begin
                mh = m_t / 3600;
                mm = (m_t / 60) % 60;
                ms = m_t % 60;
                if (i_inc_min)  mm = (mm + 1) % 60;
                if (i_inc_hour) mh = (mh + 1) % 24;
                m_t = mh * 3600 + mm * 60 + ms;
                m_pend = m_pend | mqt;
            end else if (mqt || m_pend) begin
                m_pend = 1'b0;
                m_t = (m_t + 1) % 86400;
                m_mp = (m_t % 60) == 0;
                m_dp = (m_t == 0);
            end
        end
    end

    always @(negedge clk50m) begin
        if (chk_en && rstn) begin
            check("sec",       o_sec_bcd,   to_bcd(m_t % 60));
            check("min",       o_min_bcd,   to_bcd((m_t / 60) % 60));
            check("hour",      o_hour_bcd,  to_bcd(m_t / 3600));
            check("min_pulse", o_min_pulse, m_mp);
            check("day_pulse", o_day_pulse, m_dp);
            check("hex0", o_hex0, seg_lo(p_s[3:0]));
            check("hex1", o_hex1, seg_lo(p_s[7:4]));
            check("hex2", o_hex2, seg_lo(p_m[3:0]));
            check("hex3", o_hex3, seg_lo(p_m[7:4]));
            check("hex4", o_hex4, seg_lo(p_h[3:0]));
            check("hex5", o_hex5, seg_lo(p_h[7:4]));
        end
    end

    // One cycle of stimulus; returns 1 ns after the capturing edge.
    task automatic cyc(input bit tk, input bit rn, input bit cl, input bit im, input bit ih);
        i_tick = tk; i_run = rn; i_clr = cl; i_inc_min = im; i_inc_hour = ih;
        @(posedge clk50m);
        #1;
        $display("cyc t=%0t tick=%b run=%b clr=%b im=%b ih=%b -> %h:%h:%h mp=%b dp=%b",
                 $time, tk, rn, cl, im, ih, o_hour_bcd, o_min_bcd, o_sec_bcd, o_min_pulse, o_day_pulse);
    endtask

    task automatic preload(input int h, input int m, input int s);
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < h; i++) cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < m; i++) cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < s; i++) cyc(1, 1, 0, 0, 0);
    endtask

    task automatic check_time(input string name, input logic [23:0] exp);
        check(name, {o_hour_bcd, o_min_bcd, o_sec_bcd}, exp);
    endtask

    int pc;
    int pc0;

    initial begin
        #25;
        check_time("reset_time", 24'h000000);
        check("reset_min_pulse", o_min_pulse, 1'b0);
        check("reset_day_pulse", o_day_pulse, 1'b0);
        check("reset_hex0", o_hex0, 7'b1000000);
        check("reset_hex5", o_hex5, 7'b1000000);
        rstn = 1'b1;
        chk_en = 1'b1;

        // 60 ticks: seconds wrap, minute advances, single minute pulse at :00
        pc = 0; pc0 = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc(1, 1, 0, 0, 0);
            if (o_min_pulse) begin
                pc++;
                if (o_sec_bcd == 8'h00) pc0++;
            end
            if (i == 59) check("t1_sec59", o_sec_bcd, 8'h59);
        end
        check_time("t1_final", 24'h000100);
        check("t1_pulse_count", pc, 1);
        check("t1_pulse_at_00", pc0, 1);

        // Day rollover
        preload(23, 59, 58);
        check_time("t2_preload", 24'h235958);
        cyc(1, 1, 0, 0, 0);
        check_time("t2_235959", 24'h235959);
        check("t2_no_pulse", {o_min_pulse, o_day_pulse}, 2'b00);
        cyc(1, 1, 0, 0, 0);
        check_time("t2_wrap", 24'h000000);
        check("t2_pulses", {o_min_pulse, o_day_pulse}, 2'b11);
        cyc(0, 1, 0, 0, 0);
        check("t2_pulses_drop", {o_min_pulse, o_day_pulse}, 2'b00);

        // Adjust colliding with tick: tick deferred one cycle
        preload(0, 0, 5);
        cyc(1, 1, 0, 1, 0);
        check_time("t3_adjust", 24'h000105);
        cyc(0, 1, 0, 0, 0);
        check_time("t3_deferred", 24'h000106);

        // Clear wins over tick
        preload(12, 34, 56);
        check_time("t4_preload", 24'h123456);
        cyc(1, 1, 1, 0, 0);
        check_time("t4_clr", 24'h000000);
        check("t4_no_pulse", {o_min_pulse, o_day_pulse}, 2'b00);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check_time("t4_after", 24'h000001);

        // Hex latency and frozen time
        preload(0, 0, 7);
        check("t5_hex0_old", o_hex0, 7'b0000010);
        cyc(0, 1, 0, 0, 0);
        check("t5_hex0_seven", o_hex0, 7'b1111000);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
        check_time("t5_frozen", 24'h000007);

        // Asynchronous reset mid-cycle
        preload(5, 43, 21);
        check_time("t6_preload", 24'h054321);
        #3 rstn = 1'b0;
        #1;
        check_time("t6_async_time", 24'h000000);
        check("t6_async_hex0", o_hex0, 7'b1000000);
        check("t6_async_hex3", o_hex3, 7'b1000000);
        check("t6_async_pulses", {o_min_pulse, o_day_pulse}, 2'b00);
        #4 rstn = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 99) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end
        cyc(0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
